// File: rtl/atm_bank_responder.sv
// Bank-side account server: PIN check, lockout, one login session, deposit/withdraw/balance.
// Optional CHANGE_PIN op (101) is built only when ATM_PIN_CHANGE_EN is defined.
module atm_bank_responder #(
    parameter int NUM_ACCTS    = 4,
    parameter int ACCT_W       = 2,
    parameter int BAL_W        = 8,
    parameter int AMT_W        = 6,
    parameter int PIN_W        = 4,
    parameter int MAX_TRIES    = 3,
    parameter int INIT_BALANCE = 30,
    parameter logic [PIN_W-1:0] DEFAULT_PIN = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [ACCT_W-1:0]    req_acct,
    input  logic [PIN_W-1:0]     req_pin,
    input  logic [AMT_W-1:0]     req_amount,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_status,
    output logic [BAL_W-1:0]     rsp_balance,
    output logic [NUM_ACCTS-1:0] acct_locked,
    output logic                 session_active,
    output logic [ACCT_W-1:0]    session_acct
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;

    localparam logic [2:0] OP_VERIFY = 3'd0, OP_DEPOSIT = 3'd1, OP_WITHDRAW = 3'd2,
                           OP_BALANCE = 3'd3, OP_LOGOUT = 3'd4, OP_CHPIN = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_LOCKED = 3'd2, ST_NO_SESS = 3'd3,
                           ST_INSUFF = 3'd4, ST_OVF = 3'd5, ST_BAD_OP = 3'd6;
    localparam logic [1:0]       MAX_T    = 2'(MAX_TRIES);
    localparam logic [BAL_W-1:0] INIT_BAL = BAL_W'(INIT_BALANCE);

    state_t             state;
    logic [2:0]         l_op;
    logic [ACCT_W-1:0]  l_acct;
    logic [PIN_W-1:0]   l_pin;
    logic [AMT_W-1:0]   l_amount;
    logic [BAL_W-1:0]   bal   [NUM_ACCTS];
    logic [1:0]         tries [NUM_ACCTS];
`ifdef ATM_PIN_CHANGE_EN
    logic [PIN_W-1:0]   pins  [NUM_ACCTS];
    logic               c_wr_pin, p_wr_pin;
`endif

    logic [BAL_W-1:0]   cur_bal, amt_ext, c_bal, p_bal;
    logic [BAL_W:0]     sum;
    logic [PIN_W-1:0]   cur_pin;
    logic [1:0]         c_tries, p_tries;
    logic [2:0]         c_status, p_status;
    logic               sess_ok;
    logic               c_wr_bal, c_wr_tries, c_lock, c_open, c_close;
    logic               p_wr_bal, p_wr_tries, p_lock, p_open, p_close;

    always_comb begin
        cur_bal = bal[l_acct];
        amt_ext = BAL_W'(l_amount);
        sum     = {1'b0, cur_bal} + {1'b0, amt_ext};
        sess_ok = session_active && (session_acct == l_acct);
`ifdef ATM_PIN_CHANGE_EN
        cur_pin  = pins[l_acct];
        c_wr_pin = 1'b0;
`else
        cur_pin  = DEFAULT_PIN;
`endif
        c_status   = ST_BAD_OP;
        c_bal      = cur_bal;
        c_tries    = tries[l_acct];
        c_wr_bal   = 1'b0;
        c_wr_tries = 1'b0;
        c_lock     = 1'b0;
        c_open     = 1'b0;
        c_close    = 1'b0;
        case (l_op)
            OP_VERIFY: begin
                if (acct_locked[l_acct]) begin
                    c_status = ST_LOCKED;
                end else if (l_pin == cur_pin) begin
                    c_status   = ST_OK;
                    c_tries    = 2'd0;
                    c_wr_tries = 1'b1;
                    c_open     = 1'b1;
                end else begin
                    // A wrong PIN on any account ends whatever session is open.
                    c_tries    = tries[l_acct] + 2'd1;
                    c_wr_tries = 1'b1;
                    c_close    = 1'b1;
                    c_lock     = (c_tries >= MAX_T);
                    c_status   = c_lock ? ST_LOCKED : ST_BAD_PIN;
                end
            end
            OP_DEPOSIT: begin
                if (!sess_ok)          c_status = ST_NO_SESS;
                else if (sum[BAL_W])   c_status = ST_OVF;
                else begin
                    c_status = ST_OK;
                    c_bal    = sum[BAL_W-1:0];
                    c_wr_bal = 1'b1;
                end
            end
            OP_WITHDRAW: begin
                if (!sess_ok)               c_status = ST_NO_SESS;
                else if (amt_ext > cur_bal) c_status = ST_INSUFF;
                else begin
                    c_status = ST_OK;
                    c_bal    = cur_bal - amt_ext;
                    c_wr_bal = 1'b1;
                end
            end
            OP_BALANCE: c_status = sess_ok ? ST_OK : ST_NO_SESS;
            OP_LOGOUT: begin
                c_status = ST_OK;
                c_close  = 1'b1;
            end
`ifdef ATM_PIN_CHANGE_EN
            OP_CHPIN: begin
                if (!sess_ok) c_status = ST_NO_SESS;
                else begin
                    c_status   = ST_OK;
                    c_wr_pin   = 1'b1;
                    c_tries    = 2'd0;
                    c_wr_tries = 1'b1;
                end
            end
`endif
            default: c_status = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_status     <= 3'd0;
            rsp_balance    <= '0;
            acct_locked    <= '0;
            session_active <= 1'b0;
            session_acct   <= '0;
            l_op <= '0; l_acct <= '0; l_pin <= '0; l_amount <= '0;
            p_status <= '0; p_bal <= '0; p_tries <= '0;
            p_wr_bal <= 1'b0; p_wr_tries <= 1'b0; p_lock <= 1'b0; p_open <= 1'b0; p_close <= 1'b0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal[i]   <= INIT_BAL;
                tries[i] <= 2'd0;
`ifdef ATM_PIN_CHANGE_EN
                pins[i]  <= DEFAULT_PIN;
`endif
            end
`ifdef ATM_PIN_CHANGE_EN
            p_wr_pin <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    l_op      <= req_op;
                    l_acct    <= req_acct;
                    l_pin     <= req_pin;
                    l_amount  <= req_amount;
                    req_ready <= 1'b0;
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    p_status <= c_status; p_bal <= c_bal; p_tries <= c_tries;
                    p_wr_bal <= c_wr_bal; p_wr_tries <= c_wr_tries;
                    p_lock <= c_lock; p_open <= c_open; p_close <= c_close;
`ifdef ATM_PIN_CHANGE_EN
                    p_wr_pin <= c_wr_pin;
`endif
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // Commit happens on the edge leaving EXEC, so a reset before it drops the op.
                    if (p_wr_bal)   bal[l_acct]   <= p_bal;
                    if (p_wr_tries) tries[l_acct] <= p_tries;
                    if (p_lock)     acct_locked[l_acct] <= 1'b1;
`ifdef ATM_PIN_CHANGE_EN
                    if (p_wr_pin)   pins[l_acct]  <= l_pin;
`endif
                    if (p_open) begin
                        session_active <= 1'b1;
                        session_acct   <= l_acct;
                    end else if (p_close) begin
                        session_active <= 1'b0;
                    end
                    rsp_status  <= p_status;
                    rsp_balance <= p_bal;
                    rsp_valid   <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed vector bench for atm_bank_responder: table of transactions plus hand sequences.
module tb_atm_bank_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] req_op = '0;
    logic [1:0] req_acct = '0;
    logic [3:0] req_pin = '0;
    logic [5:0] req_amount = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [2:0] rsp_status;
    logic [7:0] rsp_balance;
    logic [3:0] acct_locked;
    logic       session_active;
    logic [1:0] session_acct;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    atm_bank_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_acct(req_acct),
        .req_pin(req_pin), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .acct_locked(acct_locked),
        .session_active(session_active), .session_acct(session_acct)
    );

    localparam logic [2:0] OK = 0, BADPIN = 1, LOCKED = 2, NOSESS = 3, INSUFF = 4, OVF = 5, BADOP = 6;

    typedef struct {
        logic [2:0] op;
        logic [1:0] acct;
        logic [3:0] pin;
        logic [5:0] amt;
        logic [2:0] exp_st;
        logic [7:0] exp_bal;
        logic       exp_sess;
        logic [1:0] exp_sacct;
        logic [3:0] exp_lock;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction; request fields are scrambled after acceptance to prove they were latched.
    task automatic run(input logic [2:0] op, input logic [1:0] acct, input logic [3:0] pin,
                       input logic [5:0] amt, input logic [2:0] exp_st, input logic [7:0] exp_bal,
                       input int hold, input string name);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_acct = acct; req_pin = pin; req_amount = amt;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk({name, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'b111; req_acct = ~acct; req_pin = ~pin; req_amount = ~amt;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk({name, " latency"}, 32'(lat), 32'd3);
        chk({name, " status"}, 32'(rsp_status), 32'(exp_st));
        chk({name, " balance"}, 32'(rsp_balance), 32'(exp_bal));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({name, " hold ready"}, 32'(req_ready), 32'd0);
            chk({name, " hold status"}, 32'(rsp_status), 32'(exp_st));
            chk({name, " hold balance"}, 32'(rsp_balance), 32'(exp_bal));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, " ready after"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 2'd0, 4'hF, 6'd0,  OK,     8'd30,  1'b1, 2'd0, 4'b0000};
        tbl[1]  = '{3'd1, 2'd0, 4'h0, 6'd20, OK,     8'd50,  1'b1, 2'd0, 4'b0000};
        tbl[2]  = '{3'd2, 2'd0, 4'h0, 6'd51, INSUFF, 8'd50,  1'b1, 2'd0, 4'b0000};
        tbl[3]  = '{3'd2, 2'd0, 4'h0, 6'd50, OK,     8'd0,   1'b1, 2'd0, 4'b0000};
        tbl[4]  = '{3'd2, 2'd0, 4'h0, 6'd0,  OK,     8'd0,   1'b1, 2'd0, 4'b0000};
        tbl[5]  = '{3'd0, 2'd1, 4'hF, 6'd0,  OK,     8'd30,  1'b1, 2'd1, 4'b0000};
        tbl[6]  = '{3'd1, 2'd1, 4'h0, 6'd63, OK,     8'd93,  1'b1, 2'd1, 4'b0000};
        tbl[7]  = '{3'd1, 2'd1, 4'h0, 6'd63, OK,     8'd156, 1'b1, 2'd1, 4'b0000};
        tbl[8]  = '{3'd1, 2'd1, 4'h0, 6'd63, OK,     8'd219, 1'b1, 2'd1, 4'b0000};
        tbl[9]  = '{3'd1, 2'd1, 4'h0, 6'd63, OVF,    8'd219, 1'b1, 2'd1, 4'b0000};
        tbl[10] = '{3'd1, 2'd0, 4'h0, 6'd5,  NOSESS, 8'd0,   1'b1, 2'd1, 4'b0000};
        tbl[11] = '{3'd0, 2'd2, 4'h0, 6'd0,  BADPIN, 8'd30,  1'b0, 2'd0, 4'b0000};
        tbl[12] = '{3'd0, 2'd2, 4'h0, 6'd0,  BADPIN, 8'd30,  1'b0, 2'd0, 4'b0000};
        tbl[13] = '{3'd0, 2'd2, 4'h0, 6'd0,  LOCKED, 8'd30,  1'b0, 2'd0, 4'b0100};
        tbl[14] = '{3'd0, 2'd2, 4'hF, 6'd0,  LOCKED, 8'd30,  1'b0, 2'd0, 4'b0100};
        tbl[15] = '{3'd3, 2'd3, 4'h0, 6'd0,  NOSESS, 8'd30,  1'b0, 2'd0, 4'b0100};
        tbl[16] = '{3'd7, 2'd3, 4'h0, 6'd0,  BADOP,  8'd30,  1'b0, 2'd0, 4'b0100};
        tbl[17] = '{3'd4, 2'd3, 4'h0, 6'd0,  OK,     8'd30,  1'b0, 2'd0, 4'b0100};

        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_status", 32'(rsp_status), 32'd0);
        chk("reset rsp_balance", 32'(rsp_balance), 32'd0);
        chk("reset acct_locked", 32'(acct_locked), 32'd0);
        chk("reset session_active", 32'(session_active), 32'd0);
        chk("reset session_acct", 32'(session_acct), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run(tbl[i].op, tbl[i].acct, tbl[i].pin, tbl[i].amt, tbl[i].exp_st, tbl[i].exp_bal,
                0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d session_active", i), 32'(session_active), 32'(tbl[i].exp_sess));
            if (tbl[i].exp_sess)
                chk($sformatf("vec%0d session_acct", i), 32'(session_acct), 32'(tbl[i].exp_sacct));
            chk($sformatf("vec%0d acct_locked", i), 32'(acct_locked), 32'(tbl[i].exp_lock));
        end

        // Response backpressure: rsp_ready low for 10 cycles.
        run(3'd3, 2'd3, 4'h0, 6'd0, NOSESS, 8'd30, 10, "hold");

        // Reset during EXEC of a deposit: no response, nothing committed.
        do_reset();
        run(3'd0, 2'd3, 4'hF, 6'd0, OK, 8'd30, 0, "rst verify");
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_acct = 2'd3; req_amount = 6'd10;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rst mid req_ready", 32'(req_ready), 32'd1);
        chk("rst mid session", 32'(session_active), 32'd0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            chk("rst mid no response", 32'(seen), 32'd0);
        end
        run(3'd0, 2'd3, 4'hF, 6'd0, OK, 8'd30, 0, "rst reverify");
        run(3'd3, 2'd3, 4'h0, 6'd0, OK, 8'd30, 0, "rst balance");

        // PIN change on account 1.
        run(3'd0, 2'd1, 4'hF, 6'd0, OK, 8'd30, 0, "chpin login");
`ifdef ATM_PIN_CHANGE_EN
        run(3'd5, 2'd1, 4'b0101, 6'd0, OK, 8'd30, 0, "chpin op");
        run(3'd0, 2'd1, 4'b0101, 6'd0, OK, 8'd30, 0, "chpin verify new");
        run(3'd0, 2'd1, 4'hF, 6'd0, BADPIN, 8'd30, 0, "chpin old rejected");
`else
        run(3'd5, 2'd1, 4'b0101, 6'd0, BADOP, 8'd30, 0, "chpin op");
        run(3'd0, 2'd1, 4'b0101, 6'd0, BADPIN, 8'd30, 0, "chpin verify new");
        run(3'd0, 2'd1, 4'hF, 6'd0, OK, 8'd30, 0, "chpin old kept");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/atm_bank_responder.md
# atm_bank_responder

Bank-side account server answering transaction requests issued by the ATM front-end controller. Holds per-account balances, PINs, failed-attempt counters and lockout flags, plus a single login session. Accepts one request at a time over a valid/ready handshake and returns a status code and the resulting balance over a second valid/ready handshake.

## Interface
- NUM_ACCTS, 4, number of accounts (power of two, ≥2)
- ACCT_W, 2, log2(NUM_ACCTS)
- BAL_W, 8, balance width
- AMT_W, 6, amount width
- PIN_W, 4, PIN width
- MAX_TRIES, 3, wrong PINs that lock an account (1..3)
- INIT_BALANCE, 30, balance of every account after reset
- DEFAULT_PIN, 4'b1111, PIN of every account after reset

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_op  in  3  000 VERIFY, 001 DEPOSIT, 010 WITHDRAW, 011 BALANCE, 100 LOGOUT, 101 CHANGE_PIN (macro-gated), others invalid
- req_acct  in  ACCT_W  target account
- req_pin  in  PIN_W  PIN (VERIFY) or new PIN (CHANGE_PIN)
- req_amount  in  AMT_W  amount (DEPOSIT/WITHDRAW)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 NO_SESSION, 4 INSUFFICIENT, 5 OVERFLOW, 6 BAD_OP
- rsp_balance  out  BAL_W  balance of req_acct after the operation
- acct_locked  out  NUM_ACCTS  per-account lock flags
- session_active  out  1  a session is open
- session_acct  out  ACCT_W  account owning the session

## Operation
- FSM: IDLE → CHECK → EXEC → RESP → IDLE. req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
- Request accepted on edge where req_valid&&req_ready; all req_* fields latched then; later changes ignored.
- CHECK: decodes op, evaluates lock, PIN, session, arithmetic; produces status. EXEC: commits state updates only when status is OK (or the lock/counter update for VERIFY). RESP: holds rsp_status/rsp_balance stable until rsp_valid&&rsp_ready, then IDLE.
- VERIFY: locked account → LOCKED, no counter change. Correct PIN → OK, counter cleared, session opened on req_acct (replacing any other). Wrong PIN → counter+1, any open session closed; if counter reaches MAX_TRIES → lock set, status LOCKED, else BAD_PIN.
- DEPOSIT/WITHDRAW/BALANCE/CHANGE_PIN require session_active and session_acct==req_acct, else NO_SESSION, no change.
- DEPOSIT: sum computed BAL_W+1 wide; sum > 2^BAL_W−1 → OVERFLOW, no change.
- WITHDRAW: amount > balance → INSUFFICIENT, no change; amount==balance → OK, balance 0.
- Zero amount → OK, no change.
- LOGOUT: always OK; closes session if open.
- Invalid op → BAD_OP, no change.
- rsp_balance: balance of latched req_acct after EXEC, for every status.
- Lock cleared only by rst.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0, acct_locked=0, session_active=0, session_acct=0; all balances INIT_BALANCE, PINs DEFAULT_PIN, counters 0.
- Accept on edge E0; CHECK after E0, EXEC after E1, rsp_valid=1 after E2 (3-cycle latency to response). Balance/lock/session outputs update at E2.
- Response accepted at edge E3 (rsp_ready held high) → req_ready=1 after E3; minimum 4 cycles per transaction.
- rsp_ready low: RESP held indefinitely, outputs stable.
- rst mid-transaction: immediate return to reset values; uncommitted operation discarded; response never issued.

## Configuration
- ATM_PIN_CHANGE_EN defined: op 101 CHANGE_PIN with valid session → OK, PIN of req_acct replaced by req_pin, counter cleared.
- Not defined: op 101 → BAD_OP; PINs constant DEFAULT_PIN; no PIN storage writes.

## Test plan
- Reset, VERIFY acct 0 PIN 1111 → OK, balance 30, session_active=1, session_acct=0, rsp_valid 3 cycles after accept.
- Session acct 0: DEPOSIT 20 → OK/50; WITHDRAW 51 → INSUFFICIENT/50; WITHDRAW 50 → OK/0.
- Session acct 1, deposit 63 four times from 30 → OK 93,156,219, fourth OVERFLOW/219.
- VERIFY acct 2 PIN 0000 ×3 → BAD_PIN, BAD_PIN, LOCKED; acct_locked=0100; then PIN 1111 → LOCKED.
- No session: BALANCE acct 3 → NO_SESSION; op 111 → BAD_OP; hold rsp_ready=0 10 cycles → outputs stable, req_ready=0.
- rst asserted during EXEC of DEPOSIT 10 → rsp_valid never asserted, balance stays 30; with ATM_PIN_CHANGE_EN CHANGE_PIN 0101 then VERIFY 0101 → OK, without macro CHANGE_PIN → BAD_OP.
